// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback: frame width and FSM state encodings.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-FF synchroniser, start-bit glitch rejection and framing-error discard.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] data_out,
  output logic       rx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic            sync1_reg, sync2_reg, prev_reg;
  rx_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            done_reg, done_next;
  logic            ferr_reg, ferr_next;

  // Synchroniser plus one delayed copy for falling-edge detection; idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx_line;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state logic: sample at bit centres, half a bit after the detected start edge
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    ferr_next  = ferr_reg;
    case (state_reg)
      RX_IDLE: begin
        cnt_next  = '0;
        idx_next  = '0;
        ferr_next = 1'b0;
        if (prev_reg && !sync2_reg) begin
          state_next = RX_START;
        end
      end
      RX_START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next   = '0;
          idx_next   = '0;
          // A start bit that has gone high again by mid-bit was a glitch
          state_next = sync2_reg ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          if (idx_reg == LAST_BIT) begin
            state_next = RX_STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (ferr_reg) begin
          // Bad stop bit: hold off until the line returns high so no false start is seen
          if (sync2_reg) begin
            ferr_next  = 1'b0;
            state_next = RX_IDLE;
          end
        end else if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (sync2_reg) begin
            data_next  = shift_reg;
            done_next  = 1'b1;
            state_next = RX_IDLE;
          end else begin
            ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

  assign data_out = data_reg;
  assign rx_done  = done_reg;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// The serial line is registered so it changes exactly on bit boundaries.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       tx_line,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  // tx_done is registered, so it is armed one cycle early to land on the last stop cycle
  localparam logic [CW-1:0] DONE_CNT = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            line_reg, line_next;
  logic            done_reg, done_next;

  // State and datapath registers; reset aborts any frame and idles the line high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= TX_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      line_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      line_reg  <= line_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: the line value for the coming bit is loaded at each bit boundary
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    line_next  = line_reg;
    done_next  = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        line_next = 1'b1;
        cnt_next  = '0;
        idx_next  = '0;
        if (send) begin
          shift_next = data_in;
          line_next  = 1'b0;
          state_next = TX_START;
        end
      end
      TX_START: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          idx_next   = '0;
          line_next  = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          state_next = TX_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (idx_reg == LAST_BIT) begin
            line_next  = 1'b1;
            state_next = TX_STOP;
          end else begin
            idx_next   = idx_reg + 1'b1;
            line_next  = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      TX_STOP: begin
        done_next = (cnt_reg == DONE_CNT);
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = TX_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = TX_IDLE;
        line_next  = 1'b1;
      end
    endcase
  end

  assign tx_line = line_reg;
  assign tx_done = done_reg;

endmodule

// File: rtl/uart_top_module.sv
// UART loopback self-test: transmitter output drives the receiver input internally.
module uart_top_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic [7:0] data_out,
  output logic       tx_done,
  output logic       rx_done
);

  logic serial_line;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .send   (send),
    .tx_line(serial_line),
    .tx_done(tx_done)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_line (serial_line),
    .data_out(data_out),
    .rx_done (rx_done)
  );

endmodule

// File: tb/tb_uart_top_module.sv
// Directed bench for the UART loopback with CLKS_PER_BIT = 16.
module tb_uart_top_module;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       send;
  logic [7:0] data_out;
  logic       tx_done;
  logic       rx_done;

  int checks = 0;
  int errors = 0;

  uart_top_module #(
    .CLKS_PER_BIT(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .send    (send),
    .data_out(data_out),
    .tx_done (tx_done),
    .rx_done (rx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count done pulses over n cycles, sampled on falling edges
  task automatic watch(input int n, output int rxc, output int txc);
    rxc = 0;
    txc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rx_done) rxc++;
      if (tx_done) txc++;
    end
  endtask

  // One frame: inj=1 fires an ignored send of 55 mid-frame, inj=2 forces the stop bit low.
  // Cycle 1 is the first cycle after the accepting edge; bit k spans cycles 16k+1..16k+16.
  task automatic frame(input logic [7:0] b, input logic [7:0] exp_out, input int exp_rx,
                       input int inj, input string tag);
    logic [9:0] bits;
    logic [9:0] exp_bits;
    logic       idle_line;
    int rxc, txc, rx_at, tx_at;
    rxc = 0; txc = 0; rx_at = 0; tx_at = 0;
    bits = '0;
    idle_line = 1'b0;
    @(negedge clk);
    data_in = b;
    send    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    for (int cyc = 1; cyc <= 175; cyc++) begin
      if ((cyc % 16 == 8) && (cyc < 160)) bits[(cyc - 8) / 16] = dut.serial_line;
      if (cyc == 170) idle_line = dut.serial_line;
      if (tx_done) begin txc++; tx_at = cyc; end
      if (rx_done) begin rxc++; rx_at = cyc; end
      if (inj == 1 && cyc == 20) begin data_in = 8'h55; send = 1'b1; end
      if (inj == 1 && cyc == 21) send = 1'b0;
      if (inj == 2 && cyc == 146) force dut.serial_line = 1'b0;
      if (inj == 2 && cyc == 158) release dut.serial_line;
      @(negedge clk);
    end
    exp_bits = {(inj == 2) ? 1'b0 : 1'b1, b, 1'b0};
    chk({tag, "_line_bits"}, 32'(bits), 32'(exp_bits));
    chk({tag, "_tx_pulses"}, 32'(txc), 32'd1);
    chk({tag, "_tx_cycle"}, 32'(tx_at), 32'd160);
    chk({tag, "_rx_pulses"}, 32'(rxc), 32'(exp_rx));
    if (exp_rx == 1) chk({tag, "_rx_before_tx"}, 32'(rx_at < tx_at), 32'd1);
    chk({tag, "_data_out"}, 32'(data_out), 32'(exp_out));
    chk({tag, "_idle_after"}, 32'(idle_line), 32'd1);
    $display("frame %s: sent %02h data_out %02h rx_done %0d at %0d tx_done %0d at %0d",
             tag, b, data_out, rxc, rx_at, txc, tx_at);
  endtask

  initial begin
    int rxc, txc;
    rst     = 1'b0;
    send    = 1'b0;
    data_in = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_line", 32'(dut.serial_line), 32'd1);
    rst = 1'b1;
    watch(40, rxc, txc);
    chk("idle_rx_pulses", 32'(rxc), 32'd0);
    chk("idle_tx_pulses", 32'(txc), 32'd0);
    chk("idle_line", 32'(dut.serial_line), 32'd1);
    $display("reset released: data_out %02h, no activity", data_out);

    // Basic frame and back-to-back extremes
    frame(8'h6A, 8'h6A, 1, 0, "f6A");
    frame(8'h00, 8'h00, 1, 0, "f00");
    frame(8'hFF, 8'hFF, 1, 0, "fFF");

    // Send during a frame is ignored and data_in changes do not disturb the latched byte
    frame(8'hC3, 8'hC3, 1, 1, "fC3_busy");
    watch(60, rxc, txc);
    chk("busy_no_extra_rx", 32'(rxc), 32'd0);
    chk("busy_no_extra_tx", 32'(txc), 32'd0);

    // Reset in the middle of the data bits of A5
    @(negedge clk);
    data_in = 8'hA5;
    send    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_data_out", 32'(data_out), 32'h00);
    chk("midrst_line", 32'(dut.serial_line), 32'd1);
    chk("midrst_tx_done", 32'(tx_done), 32'd0);
    chk("midrst_rx_done", 32'(rx_done), 32'd0);
    watch(5, rxc, txc);
    rst = 1'b1;
    watch(200, rxc, txc);
    chk("midrst_rx_pulses", 32'(rxc), 32'd0);
    chk("midrst_tx_pulses", 32'(txc), 32'd0);
    chk("midrst_data_hold", 32'(data_out), 32'h00);
    $display("mid-frame reset: data_out %02h", data_out);
    frame(8'h3C, 8'h3C, 1, 0, "f3C");

    // Short low glitch on an idle line
    @(negedge clk);
    force dut.serial_line = 1'b0;
    repeat (4) @(negedge clk);
    release dut.serial_line;
    watch(200, rxc, txc);
    chk("glitch_rx_pulses", 32'(rxc), 32'd0);
    chk("glitch_data_out", 32'(data_out), 32'h3C);
    $display("glitch: rx_done %0d data_out %02h", rxc, data_out);

    // Framing error, then recovery on a clean frame
    frame(8'h81, 8'h3C, 0, 2, "f81_ferr");
    frame(8'h96, 8'h96, 1, 0, "f96");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
